// File: rtl/nf10_axis_pkg.sv
// ---------------------------------------------------------------------------
// nf10_axis_pkg
// Shared definitions for the NetFPGA-10G AXI-Stream plumbing (TX arbiter,
// RX demux): default stream widths, the arbiter state encoding and a
// constant-foldable clog2 helper for sizing index ports.
// ---------------------------------------------------------------------------
package nf10_axis_pkg;

    localparam int AXIS_DATA_WIDTH  = 64;
    localparam int AXIS_STRB_WIDTH  = AXIS_DATA_WIDTH / 8;
    localparam int AXIS_TUSER_WIDTH = 128;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Smallest r with 2**r >= value; returns at least 1 so that an index
    // port never collapses to zero width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nf10_rr_pick.sv
// ---------------------------------------------------------------------------
// nf10_rr_pick
// Combinational round-robin priority encoder. Searches req starting at
// (last_grant + 1) mod N and wrapping, so the most recently served index has
// the lowest priority.
//
// Ports:
//   req        in  N       request vector
//   last_grant in  IW      index granted most recently
//   next_idx   out IW      first requesting index after last_grant
//                          (equals last_grant when nothing requests)
//   any_req    out 1       at least one request is present
// ---------------------------------------------------------------------------
module nf10_rr_pick
    import nf10_axis_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] next_idx,
    output logic          any_req
);

    logic          found;
    int            cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        next_idx = last_grant;
        any_req  = |req;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // k = N revisits last_grant itself, so a lone requester that was
        // just served can still be picked again.
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(last_grant) + k) % N;
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                next_idx = cand_idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf10_10g_tx_arbiter.sv
// ---------------------------------------------------------------------------
// nf10_10g_tx_arbiter
// Packet-granular round-robin arbiter sharing the 10G interface's single
// AXI-Stream TX port among C_NUM_INPUTS requesters. A granted input owns the
// port until its tlast beat is accepted, so frames never interleave. Data is
// muxed combinationally; only the grant index and the state are registered.
//
// Ports:
//   axi_aclk       in   1                     clock
//   axi_resetn     in   1                     synchronous active-low reset
//   s_axis_tdata   in   N*C_AXIS_DATA_WIDTH   input i at [W*i +: W]
//   s_axis_tstrb   in   N*C_AXIS_DATA_WIDTH/8
//   s_axis_tuser   in   N*C_AXIS_TUSER_WIDTH
//   s_axis_tvalid  in   N
//   s_axis_tready  out  N                     only the granted bit can be 1
//   s_axis_tlast   in   N
//   m_axis_*       out                        towards the 10G interface
//   m_axis_tready  in   1
//   grant_idx      out  clog2(N)              current or last granted input
//   pkt_count      out  N*32                  only with NF10_TX_ARB_STATS_EN:
//                                             per-input accepted-frame count
//
// Build option: define NF10_TX_ARB_STATS_EN to add the pkt_count counters.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; all ready low, m_axis zeroed; pick next requester
// XFER  | grant_idx owns m_axis until its tlast beat is accepted
// ---------------------------------------------------------------------------
module nf10_10g_tx_arbiter
    import nf10_axis_pkg::*;
#(
    parameter int C_NUM_INPUTS       = 4,
    parameter int C_AXIS_DATA_WIDTH  = AXIS_DATA_WIDTH,
    parameter int C_AXIS_TUSER_WIDTH = AXIS_TUSER_WIDTH
) (
    input  logic                                        axi_aclk,
    input  logic                                        axi_resetn,

    input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_NUM_INPUTS*(C_AXIS_DATA_WIDTH/8)-1:0] s_axis_tstrb,
    input  logic [C_NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [C_NUM_INPUTS-1:0]                       s_axis_tvalid,
    output logic [C_NUM_INPUTS-1:0]                       s_axis_tready,
    input  logic [C_NUM_INPUTS-1:0]                       s_axis_tlast,

    output logic [C_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]                m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          m_axis_tlast,

    output logic [clog2(C_NUM_INPUTS)-1:0]                grant_idx
`ifdef NF10_TX_ARB_STATS_EN
    ,
    output logic [C_NUM_INPUTS*32-1:0]                    pkt_count
`endif
);

    localparam int GW = clog2(C_NUM_INPUTS);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;

    arb_state_t     state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  pick_idx;
    logic           any_req;
    logic           xfer;
    logic           beat_done;

    logic [DW-1:0]  sel_data;
    logic [SW-1:0]  sel_strb;
    logic [UW-1:0]  sel_user;
    logic           sel_valid;
    logic           sel_last;

    nf10_rr_pick #(
        .N  (C_NUM_INPUTS),
        .IW (GW)
    ) u_pick (
        .req        (s_axis_tvalid),
        .last_grant (grant_q),
        .next_idx   (pick_idx),
        .any_req    (any_req)
    );

    // Reset leaves grant at the highest index so input 0 is searched first.
    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            state_q <= IDLE;
            grant_q <= GW'(C_NUM_INPUTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign xfer = (state_q == XFER);

    // Select by comparison rather than indexing with grant_q directly, which
    // keeps non-power-of-two input counts free of out-of-range selects.
    always_comb begin
        sel_data  = '0;
        sel_strb  = '0;
        sel_user  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < C_NUM_INPUTS; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data  = s_axis_tdata[i*DW +: DW];
                sel_strb  = s_axis_tstrb[i*SW +: SW];
                sel_user  = s_axis_tuser[i*UW +: UW];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < C_NUM_INPUTS; i++) begin
            s_axis_tready[i] = xfer && (grant_q == GW'(i)) && m_axis_tready;
        end
    end

    assign m_axis_tdata  = xfer ? sel_data  : '0;
    assign m_axis_tstrb  = xfer ? sel_strb  : '0;
    assign m_axis_tuser  = xfer ? sel_user  : '0;
    assign m_axis_tvalid = xfer & sel_valid;
    assign m_axis_tlast  = xfer & sel_last;
    assign grant_idx     = grant_q;

    assign beat_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

`ifdef NF10_TX_ARB_STATS_EN
    logic [31:0] pkt_cnt_q [C_NUM_INPUTS];

    // Counters wrap naturally at 2**32.
    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            for (int i = 0; i < C_NUM_INPUTS; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else if (beat_done) begin
            for (int i = 0; i < C_NUM_INPUTS; i++) begin
                if (grant_q == GW'(i)) begin
                    pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < C_NUM_INPUTS; i++) begin
            pkt_count[i*32 +: 32] = pkt_cnt_q[i];
        end
    end
`endif

endmodule
